outport_uart_tx: RTL and testbench
==================================

// Module: outport_uart_tx
// PURPOSE
//  Far end of the CPU OutPort interface: accepts 32-bit words strobed out by the datapath,
//  buffers them in a small FIFO and serialises each word as 4 UART frames (byte 0 first).
//  Sits outside DataPath, fed by OutPortenable/BusMuxOut; drives the board-level serial line.
// PARAMETERS
//  CLKS_PER_BIT  16  clock cycles per serial bit (>=2)
//  FIFO_DEPTH    4   word entries; power of two, >=2
// PORTS
//  clock          in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  OutPortenable  in   1   write strobe; one word accepted per high cycle
//  BusMuxOut      in   32  word to transmit, sampled when OutPortenable=1
//  tx             out  1   serial line, idle high
//  busy           out  1   1 while FIFO non-empty or FSM not IDLE
//  full           out  1   FIFO holds FIFO_DEPTH words
//  level          out  $clog2(FIFO_DEPTH)+1  words currently buffered
//  overflow       out  1   sticky: a write arrived while full
// BEHAVIOUR
//  Reset (async, reset=0): tx=1, busy=0, full=0, level=0, overflow=0, FSM=IDLE, FIFO emptied.
//   Reset mid-frame aborts the frame immediately; tx returns high without completing.
//  FIFO: write when OutPortenable=1 && full=0; full/level are the registered pre-edge values.
//   Write while full=1: word dropped, overflow<=1 (held until reset), even if a pop occurs same edge.
//   Write and pop on the same edge (not full): both occur, level unchanged.
//   Pointers wrap modulo FIFO_DEPTH; level never exceeds FIFO_DEPTH or goes below 0.
//  FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
//   IDLE: if level>0, pop head into shift word, byte_idx<=0, -> START. Else stay, tx=1.
//   START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx<=0.
//   DATA: tx=current byte bit[bit_idx], LSB first, CLKS_PER_BIT cycles per bit; after bit 7 -> STOP
//    (or PARITY if enabled).
//   STOP: tx=1 for CLKS_PER_BIT cycles; then byte_idx<3 -> byte_idx+1, START (no idle gap);
//    byte_idx=3 -> IDLE.
//   Back-to-back words: after STOP of byte 3, IDLE pops the next word on the following edge, so one
//    idle-high cycle separates words.
//  Latency: write accepted at edge E0 -> FSM pops at E1 -> tx low from E1 onward.
//  Word time: 4*10*CLKS_PER_BIT cycles (4*11*CLKS_PER_BIT with parity); 640 at defaults.
//  Bit timer: counts 0..CLKS_PER_BIT-1, reloads 0 on every state/bit change; all outputs registered.
//  busy=0 only when IDLE and level=0.
// CONFIGURATION
//  OUTPORT_UART_PARITY_EN defined: PARITY state after DATA, tx = XOR of the 8 data bits (even
//   parity), CLKS_PER_BIT cycles; frame = 11 bits.
//  Undefined: no PARITY state, DATA -> STOP directly, frame = 10 bits (8N1).
// TESTING
//  1. Reset low, then high; hold 50 cycles -> tx=1, busy=0, level=0, full=0, overflow=0.
//  2. Write 0x000000A5 once -> tx low from E1 for 16 cycles, bits 1,0,1,0,0,1,0,1, stop; then
//     three frames of 0x00; busy falls exactly 640 cycles after E1.
//  3. Five writes in consecutive cycles (depth 4) while idle -> first popped at E1, so all five
//     accepted, overflow=0; sixth write while level=4 -> dropped, overflow=1, stays 1.
//  4. Write 0xDEADBEEF, assert reset=0 during byte 1 DATA -> tx=1 immediately, level=0, busy=0;
//     after release no further frames.
//  5. Write and FIFO pop on same edge with level=2 -> level stays 2; pointer wrap across 10 words
//     transmits all in order, byte sequence EF BE AD DE per 0xDEADBEEF.
//  6. With OUTPORT_UART_PARITY_EN: send 0x00000007 -> byte 0 parity bit=1, bytes 1-3 parity=0,
//     word time 704 cycles.

Source files
------------

// File: rtl/outport_uart_tx.sv
// rtl/outport_uart_tx.sv - OutPort word FIFO feeding a 4-byte-per-word UART transmitter
// Optional even parity bit per frame when OUTPORT_UART_PARITY_EN is defined (default 8N1).
module outport_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          OutPortenable,
    input  logic [31:0]                   BusMuxOut,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_n;
    logic          push, pop;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_n;
    logic [1:0]    byte_idx, byte_n;
    logic [31:0]   word, word_n;
    logic [7:0]    cur_byte;
    logic          tx_n;
    logic          last;

    // full and level are the registered values, so a write while full is dropped even if a pop happens
    assign push = OutPortenable && !full;
    assign pop  = (state == S_IDLE) && (level != '0);
    assign last = (timer == T_LAST);

    always_comb begin
        level_n = level;
        case ({push, pop})
            2'b10:   level_n = level + 1'b1;
            2'b01:   level_n = level - 1'b1;
            default: level_n = level;
        endcase
    end

    always_comb begin
        state_n = state;
        timer_n = timer + 1'b1;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        word_n  = word;
        case (state)
            S_IDLE: begin
                timer_n = '0;
                if (level != '0) begin
                    word_n  = mem[rd_ptr];
                    byte_n  = 2'd0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (last) begin
                    timer_n = '0;
                    bit_n   = 3'd0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (last) begin
                    timer_n = '0;
                    if (bit_idx == 3'd7) begin
`ifdef OUTPORT_UART_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end
            end
`ifdef OUTPORT_UART_PARITY_EN
            S_PARITY: begin
                if (last) begin
                    timer_n = '0;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (last) begin
                    timer_n = '0;
                    if (byte_idx == 2'd3) begin
                        state_n = S_IDLE;
                    end else begin
                        byte_n  = byte_idx + 1'b1;
                        state_n = S_START;
                    end
                end
            end
            default: begin
                timer_n = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // tx is registered from the next-state view so the start bit appears on the popping edge
    always_comb begin
        cur_byte = word_n[{byte_n, 3'b000} +: 8];
        tx_n     = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = cur_byte[bit_n];
`ifdef OUTPORT_UART_PARITY_EN
            S_PARITY: tx_n = ^cur_byte;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= BusMuxOut;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
            state    <= S_IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            word     <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level    <= level_n;
            full     <= (level_n == DEPTH_L);
            overflow <= overflow | (OutPortenable & full);
            state    <= state_n;
            timer    <= timer_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            word     <= word_n;
            tx       <= tx_n;
            busy     <= (state_n != S_IDLE) || (level_n != '0);
        end
    end

endmodule

// File: tb/tb_outport_uart_tx.sv
// tb/tb_outport_uart_tx.sv - randomized bench for outport_uart_tx against a word-timeline model
module tb_outport_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef OUTPORT_UART_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int FB     = FRAME * CPB;
    localparam int WORD_T = 4 * FB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        OutPortenable = 1'b0;
    logic [31:0] BusMuxOut = '0;
    logic        tx, busy, full, overflow;
    logic [2:0]  level;

    always #5 clock = ~clock;

    outport_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .OutPortenable(OutPortenable),
        .BusMuxOut(BusMuxOut),
        .tx(tx),
        .busy(busy),
        .full(full),
        .level(level),
        .overflow(overflow)
    );

    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    int          last_pop = -100000;
    logic [31:0] cur = '0;
    logic [31:0] q[$];
    logic        m_ovf = 1'b0;
    logic [31:0] w[10];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h cycle %0d t=%0t", tag, got, exp, n, $time);
        end
    endtask

    // The model treats the transmitter as busy for WORD_T edges starting at the popping edge,
    // and derives the line level from the offset into that word.
    task automatic step(input logic we, input logic [31:0] d);
        int         e, k, b;
        logic       push_m, pop_m, etx;
        logic [7:0] v;
        OutPortenable = we;
        BusMuxOut     = d;
        @(posedge clock);
        e = n;
        n++;
        push_m = we && (q.size() < DEPTH);
        pop_m  = (e >= last_pop + WORD_T + 1) && (q.size() > 0);
        if (we && q.size() == DEPTH) m_ovf = 1'b1;
        if (pop_m) begin
            cur      = q.pop_front();
            last_pop = e;
        end
        if (push_m) q.push_back(d);
        k   = e - last_pop;
        etx = 1'b1;
        if (k < WORD_T) begin
            v = cur[8*(k/FB) +: 8];
            b = (k % FB) / CPB;
            if (b == 0) etx = 1'b0;
            else if (b <= 8) etx = v[b-1];
            else if (FRAME == 11 && b == 9) etx = ^v;
        end
        #1;
        check("tx", tx, etx);
        check("level", level, q.size());
        check("full", full, q.size() == DEPTH);
        check("busy", busy, (k < WORD_T) || (q.size() != 0));
        check("overflow", overflow, m_ovf);
        OutPortenable = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        q.delete();
        last_pop = -100000;
        m_ovf    = 1'b0;
        repeat (cycles) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int idx;
        do_reset(3);
        repeat (50) step(1'b0, '0);
        check("t1_tx", tx, 1);
        check("t1_busy", busy, 0);
        check("t1_level", level, 0);
        check("t1_full", full, 0);
        check("t1_ovf", overflow, 0);

        step(1'b1, 32'h0000_00A5);
        repeat (WORD_T + 20) step(1'b0, '0);
        check("t2_busy_end", busy, 0);

        do_reset(2);
        for (int i = 0; i < 6; i++) step(1'b1, $urandom);
        check("t3_ovf", overflow, 1);
        check("t3_level", level, 4);
        repeat (5 * (WORD_T + 1) + 10) step(1'b0, '0);
        check("t3_ovf_sticky", overflow, 1);

        do_reset(2);
        step(1'b1, 32'hDEAD_BEEF);
        repeat (181) step(1'b0, '0);
        check("t4_pre_tx", tx, 0);
        do_reset(3);
        repeat (WORD_T + 10) step(1'b0, '0);
        check("t4_quiet_busy", busy, 0);

        do_reset(2);
        w[0] = 32'hDEAD_BEEF;
        for (int i = 1; i < 10; i++) w[i] = $urandom;
        step(1'b1, w[0]);
        step(1'b1, w[1]);
        step(1'b1, w[2]);
        for (int i = 0; i < WORD_T + 5; i++) begin
            if (n == last_pop + WORD_T + 1) break;
            step(1'b0, '0);
        end
        step(1'b1, w[3]);
        check("t5_same_edge_level", level, 2);
        idx = 4;
        for (int t = 0; t < 20000 && idx < 10; t++) begin
            if (q.size() < DEPTH) begin
                step(1'b1, w[idx]);
                idx++;
            end else begin
                step(1'b0, '0);
            end
        end
        check("t5_all_written", idx, 10);
        repeat (5 * (WORD_T + 1) + 10) step(1'b0, '0);
        check("t5_drained", level, 0);

        do_reset(2);
        for (int i = 0; i < 8000; i++) step($urandom_range(0, 999) < 4, $urandom);
        repeat (5 * (WORD_T + 1) + 10) step(1'b0, '0);
        check("t6_drained", level, 0);
        check("t6_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
